div_line: RTL and testbench

Pipelined unsigned restoring divider, the inverse companion to the team's shift-add multiplier pipeline. It accepts one dividend/divisor pair per cycle and retires one bit of quotient per pipeline stage, using one `div_cell` per stage. It sits in the same arithmetic datapath as the multiplier and uses the same `rdy`/`valid` strobes with no back-pressure.

---
 rtl/div_line_pkg.sv | 10 +
 rtl/div_line_div_cell.sv | 68 ++++++
 rtl/div_line.sv | 69 ++++++
 tb/tb_div_line.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_line_pkg.sv
// Shared arithmetic helpers for the multiplier/divider pipelines.
// Holds only width-derivation functions used to size datapath pieces.
package div_line_pkg;

  // Width of a restoring-division trial value: remainder plus one shifted-in bit.
  function automatic int trial_width(input int rem_width);
    return rem_width + 1;
  endfunction

endpackage

// File: rtl/div_line_div_cell.sv
// One registered restoring-division step: retires a single quotient bit.
// The last cell of the line also folds in the divide-by-zero result.
module div_cell
  import div_line_pkg::*;
#(
  parameter int DIVLEN_1 = 8,
  parameter int DIVLEN_2 = 8,
  parameter bit LAST     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DIVLEN_2-1:0] r_in,
  input  logic [DIVLEN_1-1:0] dvd_in,
  input  logic [DIVLEN_2-1:0] dvs_in,
  input  logic [DIVLEN_1-1:0] quot_in,
  input  logic                zero_in,
  output logic                rdy,
  output logic [DIVLEN_2-1:0] r_out,
  output logic [DIVLEN_1-1:0] dvd_out,
  output logic [DIVLEN_2-1:0] dvs_out,
  output logic [DIVLEN_1-1:0] quot_out,
  output logic                zero_out
);

  localparam int TW = trial_width(DIVLEN_2);

  logic [TW-1:0]       trial;
  logic                ge;
  logic [DIVLEN_2-1:0] r_next;
  logic [DIVLEN_1-1:0] q_next;

  // Trial subtract; the remainder is known to fit DIVLEN_2 bits, so the low bits suffice.
  always_comb begin
    trial  = {r_in, dvd_in[DIVLEN_1-1]};
    ge     = (trial >= {1'b0, dvs_in});
    r_next = ge ? (trial[DIVLEN_2-1:0] - dvs_in) : trial[DIVLEN_2-1:0];
    q_next = (quot_in << 1) | DIVLEN_1'(ge);
    if (LAST && zero_in) begin
      q_next = '1;
      r_next = '0;
    end
  end

  // Valid bit moves every cycle, independent of the data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy <= 1'b0;
    else        rdy <= en;
  end

  // Data registers load only behind a valid operand to avoid needless toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= '0;
      dvd_out  <= '0;
      dvs_out  <= '0;
      quot_out <= '0;
      zero_out <= 1'b0;
    end else if (en) begin
      r_out    <= r_next;
      dvd_out  <= dvd_in << 1;
      dvs_out  <= dvs_in;
      quot_out <= q_next;
      zero_out <= zero_in;
    end
  end

endmodule

// File: rtl/div_line.sv
// Pipelined unsigned restoring divider: one operation per cycle,
// one quotient bit per stage, DIVLEN_1 cycles of latency.
module div_line
  import div_line_pkg::*;
#(
  parameter int DIVLEN_1 = 8,
  parameter int DIVLEN_2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic [DIVLEN_1-1:0] div_1,
  input  logic [DIVLEN_2-1:0] div_2,
  output logic [DIVLEN_1-1:0] quot,
  output logic [DIVLEN_2-1:0] rem,
  output logic                div_zero,
  output logic                valid
);

  logic                v_c   [0:DIVLEN_1];
  logic [DIVLEN_2-1:0] r_c   [0:DIVLEN_1];
  logic [DIVLEN_1-1:0] dvd_c [0:DIVLEN_1];
  logic [DIVLEN_2-1:0] dvs_c [0:DIVLEN_1];
  logic [DIVLEN_1-1:0] q_c   [0:DIVLEN_1];
  logic                z_c   [0:DIVLEN_1];
  logic                unused_tail;

  assign v_c[0]   = rdy;
  assign r_c[0]   = '0;
  assign dvd_c[0] = div_1;
  assign dvs_c[0] = div_2;
  assign q_c[0]   = '0;
  assign z_c[0]   = (div_2 == '0);

  genvar k;
  generate
    for (k = 0; k < DIVLEN_1; k++) begin : g_stage
      div_cell #(
        .DIVLEN_1 (DIVLEN_1),
        .DIVLEN_2 (DIVLEN_2),
        .LAST     (k == DIVLEN_1 - 1)
      ) u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (v_c[k]),
        .r_in     (r_c[k]),
        .dvd_in   (dvd_c[k]),
        .dvs_in   (dvs_c[k]),
        .quot_in  (q_c[k]),
        .zero_in  (z_c[k]),
        .rdy      (v_c[k+1]),
        .r_out    (r_c[k+1]),
        .dvd_out  (dvd_c[k+1]),
        .dvs_out  (dvs_c[k+1]),
        .quot_out (q_c[k+1]),
        .zero_out (z_c[k+1])
      );
    end
  endgenerate

  // The dividend and divisor copies leaving the final stage have no consumer.
  assign unused_tail = ^{dvd_c[DIVLEN_1], dvs_c[DIVLEN_1]};

  assign valid    = v_c[DIVLEN_1];
  assign quot     = q_c[DIVLEN_1];
  assign rem      = r_c[DIVLEN_1];
  assign div_zero = z_c[DIVLEN_1];

endmodule

// File: tb/tb_div_line.sv
// Self-checking bench for div_line: directed cases on the default
// configuration plus random traffic on three parameterisations.
module tb_div_line;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        rdy_a, rdy_b, rdy_c;
  logic [7:0]  d1_a;  logic [7:0]  d2_a;  logic [7:0]  quot_a; logic [7:0]  rem_a;
  logic [15:0] d1_b;  logic [7:0]  d2_b;  logic [15:0] quot_b; logic [7:0]  rem_b;
  logic [7:0]  d1_c;  logic [11:0] d2_c;  logic [7:0]  quot_c; logic [11:0] rem_c;
  logic        dz_a, dz_b, dz_c;
  logic        valid_a, valid_b, valid_c;

  div_line #(.DIVLEN_1(8), .DIVLEN_2(8)) u_a (
    .clk(clk), .rst_n(rst_n), .rdy(rdy_a), .div_1(d1_a), .div_2(d2_a),
    .quot(quot_a), .rem(rem_a), .div_zero(dz_a), .valid(valid_a));

  div_line #(.DIVLEN_1(16), .DIVLEN_2(8)) u_b (
    .clk(clk), .rst_n(rst_n), .rdy(rdy_b), .div_1(d1_b), .div_2(d2_b),
    .quot(quot_b), .rem(rem_b), .div_zero(dz_b), .valid(valid_b));

  div_line #(.DIVLEN_1(8), .DIVLEN_2(12)) u_c (
    .clk(clk), .rst_n(rst_n), .rdy(rdy_c), .div_1(d1_c), .div_2(d2_c),
    .quot(quot_c), .rem(rem_c), .div_zero(dz_c), .valid(valid_c));

  int checks = 0;
  int errors = 0;
  int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;

  logic [64:0] sb_a[$];
  logic [64:0] sb_b[$];
  logic [64:0] sb_c[$];

  // Reference model: {div_zero, quotient, remainder}, widened to 32 bits each.
  function automatic logic [64:0] ref_div(input int unsigned n, input int unsigned d, input int qw);
    logic [31:0] ones;
    ones = (32'd1 << qw) - 32'd1;
    if (d == 0) return {1'b1, ones, 32'd0};
    return {1'b0, n / d, n % d};
  endfunction

  // Scoreboard monitors: every valid result is popped and compared in order.
  always @(negedge clk) begin
    if (rst_n && valid_a) begin
      logic [64:0] e;
      vcnt_a++;
      checks++;
      if (sb_a.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_a unexpected valid q=%0d r=%0d", quot_a, rem_a);
      end else begin
        e = sb_a.pop_front();
        if ({dz_a, 32'(quot_a), 32'(rem_a)} !== e) begin
          errors++;
          $display("[TB] FAIL sb_a got dz=%0d q=%0d r=%0d expected dz=%0d q=%0d r=%0d",
                   dz_a, quot_a, rem_a, e[64], e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid_b) begin
      logic [64:0] e;
      vcnt_b++;
      checks++;
      if (sb_b.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_b unexpected valid q=%0d r=%0d", quot_b, rem_b);
      end else begin
        e = sb_b.pop_front();
        if ({dz_b, 32'(quot_b), 32'(rem_b)} !== e) begin
          errors++;
          $display("[TB] FAIL sb_b got dz=%0d q=%0d r=%0d expected dz=%0d q=%0d r=%0d",
                   dz_b, quot_b, rem_b, e[64], e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid_c) begin
      logic [64:0] e;
      vcnt_c++;
      checks++;
      if (sb_c.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_c unexpected valid q=%0d r=%0d", quot_c, rem_c);
      end else begin
        e = sb_c.pop_front();
        if ({dz_c, 32'(quot_c), 32'(rem_c)} !== e) begin
          errors++;
          $display("[TB] FAIL sb_c got dz=%0d q=%0d r=%0d expected dz=%0d q=%0d r=%0d",
                   dz_c, quot_c, rem_c, e[64], e[63:32], e[31:0]);
        end
      end
    end
  end

  // Drive one operand pair on instance a for the coming edge; rdy stays high.
  task automatic issue_a(input int unsigned n, input int unsigned d);
    rdy_a = 1'b1;
    d1_a  = 8'(n);
    d2_a  = 8'(d);
    sb_a.push_back(ref_div(n, d, 8));
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rdy_a = 0; rdy_b = 0; rdy_c = 0;
    d1_a = 0; d2_a = 0; d1_b = 0; d2_b = 0; d1_c = 0; d2_c = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({quot_a, rem_a, dz_a, valid_a} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_a got %h expected 0", {quot_a, rem_a, dz_a, valid_a});
    end
    checks++;
    if ({quot_b, rem_b, dz_b, valid_b, quot_c, rem_c, dz_c, valid_c} !== 48'd0) begin
      errors++;
      $display("[TB] FAIL reset_bc got %h expected 0",
               {quot_b, rem_b, dz_b, valid_b, quot_c, rem_c, dz_c, valid_c});
    end
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_single;
    int lat;
    issue_a(200, 7);
    rdy_a = 1'b0;
    lat = 1;
    while (!valid_a && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("[TB] FAIL single_latency got %0d expected 8", lat);
    end
    checks++;
    if ({quot_a, rem_a} !== {8'd28, 8'd4}) begin
      errors++;
      $display("[TB] FAIL single_value got q=%0d r=%0d expected q=28 r=4", quot_a, rem_a);
    end
    idle_cycles(4);
  endtask

  task automatic test_boundaries;
    issue_a(255, 1);
    issue_a(5, 9);
    issue_a(0, 3);
    issue_a(255, 255);
    idle_cycles(12);
    checks++;
    if (sb_a.size() != 0) begin
      errors++;
      $display("[TB] FAIL boundaries_drain got %0d pending expected 0", sb_a.size());
    end
  endtask

  task automatic test_div_zero;
    int lat;
    issue_a(100, 0);
    issue_a(9, 3);
    rdy_a = 1'b0;
    lat = 0;
    while (!valid_a && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({valid_a, dz_a, quot_a, rem_a} !== {1'b1, 1'b1, 8'd255, 8'd0}) begin
      errors++;
      $display("[TB] FAIL div_zero got v=%0d dz=%0d q=%0d r=%0d expected v=1 dz=1 q=255 r=0",
               valid_a, dz_a, quot_a, rem_a);
    end
    @(posedge clk); #1;
    checks++;
    if ({valid_a, dz_a, quot_a, rem_a} !== {1'b1, 1'b0, 8'd3, 8'd0}) begin
      errors++;
      $display("[TB] FAIL after_zero got v=%0d dz=%0d q=%0d r=%0d expected v=1 dz=0 q=3 r=0",
               valid_a, dz_a, quot_a, rem_a);
    end
    idle_cycles(4);
  endtask

  task automatic test_back_to_back;
    int lat, cnt;
    logic [7:0] got_q[3];
    logic [7:0] got_r[3];
    issue_a(17, 5);
    issue_a(64, 8);
    issue_a(250, 16);
    rdy_a = 1'b0;
    lat = 0;
    while (!valid_a && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    cnt = 0;
    while (valid_a && cnt < 10) begin
      if (cnt < 3) begin
        got_q[cnt] = quot_a;
        got_r[cnt] = rem_a;
      end
      cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 3) begin
      errors++;
      $display("[TB] FAIL b2b_run got %0d valid cycles expected 3", cnt);
    end else begin
      checks++;
      if ({got_q[0], got_r[0], got_q[1], got_r[1], got_q[2], got_r[2]} !==
          {8'd3, 8'd2, 8'd8, 8'd0, 8'd15, 8'd10}) begin
        errors++;
        $display("[TB] FAIL b2b_values got %0d r%0d %0d r%0d %0d r%0d expected 3 r2 8 r0 15 r10",
                 got_q[0], got_r[0], got_q[1], got_r[1], got_q[2], got_r[2]);
      end
    end
    idle_cycles(4);
  endtask

  task automatic test_reset_midflight;
    int lat, base;
    issue_a(77, 3);
    issue_a(90, 7);
    rdy_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb_a.delete();
    #1;
    checks++;
    if (valid_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midflight_reset_valid got %0d expected 0", valid_a);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = vcnt_a;
    issue_a(30, 4);
    rdy_a = 1'b0;
    lat = 1;
    while (!valid_a && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("[TB] FAIL post_reset_latency got %0d expected 8", lat);
    end
    checks++;
    if ({quot_a, rem_a} !== {8'd7, 8'd2}) begin
      errors++;
      $display("[TB] FAIL post_reset_value got q=%0d r=%0d expected q=7 r=2", quot_a, rem_a);
    end
    idle_cycles(12);
    checks++;
    if (vcnt_a - base != 1) begin
      errors++;
      $display("[TB] FAIL midflight_valid_count got %0d expected 1", vcnt_a - base);
    end
  endtask

  task automatic test_random;
    int iss_a, iss_b, iss_c;
    vcnt_a = 0; vcnt_b = 0; vcnt_c = 0;
    iss_a = 0; iss_b = 0; iss_c = 0;
    for (int i = 0; i < 10000; i++) begin
      rdy_a = 1'($urandom_range(0, 1));
      rdy_b = 1'($urandom_range(0, 1));
      rdy_c = 1'($urandom_range(0, 1));
      d1_a = 8'($urandom);
      d2_a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      d1_b = 16'($urandom);
      d2_b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      d1_c = 8'($urandom);
      d2_c = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom);
      if (rdy_a) begin sb_a.push_back(ref_div(d1_a, d2_a, 8));  iss_a++; end
      if (rdy_b) begin sb_b.push_back(ref_div(d1_b, d2_b, 16)); iss_b++; end
      if (rdy_c) begin sb_c.push_back(ref_div(d1_c, d2_c, 8));  iss_c++; end
      @(posedge clk); #1;
    end
    idle_cycles(24);
    checks++;
    if (vcnt_a != iss_a || sb_a.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_a_count got %0d valids expected %0d", vcnt_a, iss_a);
    end
    checks++;
    if (vcnt_b != iss_b || sb_b.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_b_count got %0d valids expected %0d", vcnt_b, iss_b);
    end
    checks++;
    if (vcnt_c != iss_c || sb_c.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_c_count got %0d valids expected %0d", vcnt_c, iss_c);
    end
  endtask

  // Sequence every scenario, then report.
  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_div_zero();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
